// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core.
// Drives the PC and pipeline-register enables and flushes. Handles the
// post-reset flush, load-use bubbles, taken-branch squashes and data-memory
// wait states, and freezes the core in ERROR on a memory timeout.
module pipe_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  state_t            cur_st;
  logic [IW-1:0]     init_cnt;
  logic [WW-1:0]     wait_cnt;
  logic              rs1_used;
  logic              rs2_used;
  logic              mem_stall;
  logic              load_use;

  assign state = cur_st;

  // Which source registers the instruction in IF/ID actually reads
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (id_opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_IMM, OP_LOAD: rs1_used = 1'b1;
      default: ;
    endcase
  end

  // Hazard detection; x0 as a load destination never stalls
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((rs1_used & (id_rs1 == ex_rd)) |
                      (rs2_used & (id_rs2 == ex_rd)));

  // Same-cycle pipeline controls: mem_stall > branch > load_use > normal
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    unique case (cur_st)
      ST_INIT: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_flush = 1'b1;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, let ID/EX capture a bubble
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          idex_flush  = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
        end
      end
      ST_ERROR: ;
      default: ;
    endcase
  end

  // Sequencer state, init/wait counters and the sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st   <= ST_INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (cur_st)
        ST_INIT: begin
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            cur_st   <= ST_RUN;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
        ST_RUN: begin
          if (mem_stall) begin
            cur_st   <= ST_MEM_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt == WW'(MEM_TIMEOUT)) begin
              cur_st  <= ST_ERROR;
              mem_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WW'(1);
            end
          end else begin
            cur_st   <= ST_RUN;
            wait_cnt <= '0;
          end
        end
        ST_ERROR: ;
        default: cur_st <= ST_ERROR;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held while running
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((cur_st == ST_RUN || cur_st == ST_MEM_WAIT) && !pc_write &&
                 (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
